// File: rtl/interrupt_controller_pkg.sv
// mips_irq_pkg: shared state encoding, default vectors and counter width for the interrupt controller.
package mips_irq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, IRQ_SVC = 2'd1, NMI_SVC = 2'd2} state_t;
    localparam int DEF_NMI_VECTOR = 20;
    localparam int DEF_IRQ_VECTOR = 0;
    localparam int CNT_W = 8;
endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: request pins, control-unit strobes and PC-redirect outputs of the interrupt controller.
interface interrupt_controller_if #(parameter int ADDR_W = 32);
    import mips_irq_pkg::*;
    logic nmi_in;
    logic irq_in;
    logic cpu_busy;
    logic ie_set;
    logic ie_clr;
    logic instr_boundary;
    logic eret;
    logic take;
    logic save_pc;
    logic [ADDR_W-1:0] vector;
    logic pc_restore;
    logic ina;
    logic in_nmi;
    logic ie;
    logic [1:0] state;
    logic [CNT_W-1:0] taken_count;
    modport slave (
        input nmi_in, irq_in, cpu_busy, ie_set, ie_clr, instr_boundary, eret,
        output take, save_pc, vector, pc_restore, ina, in_nmi, ie, state, taken_count
    );
    modport master (
        output nmi_in, irq_in, cpu_busy, ie_set, ie_clr, instr_boundary, eret,
        input take, save_pc, vector, pc_restore, ina, in_nmi, ie, state, taken_count
    );
endinterface

// File: rtl/interrupt_controller_edge_detect.sv
// edge_detect: one-cycle rise flag for a synchronous input, compared against its registered copy.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic rise
);
    logic r_prev;
    always_ff @(posedge clock) r_prev <= reset ? 1'b0 : in;
    assign rise = in & ~r_prev;
endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: decides at instruction boundaries whether to redirect the PC to an NMI/IRQ handler
// and when to restore the saved PC on return.
module interrupt_controller
    import mips_irq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] NMI_VECTOR = ADDR_W'(DEF_NMI_VECTOR),
    parameter logic [ADDR_W-1:0] IRQ_VECTOR = ADDR_W'(DEF_IRQ_VECTOR)
) (
    input logic clock,
    input logic reset,
    interrupt_controller_if.slave bus
);
    state_t r_state;
    logic r_ie;
    logic r_ie_saved;
    logic r_nmi_pend;
    logic r_ina;
    logic r_in_nmi;
    logic [CNT_W-1:0] r_count;
    logic w_rise;
    logic w_idle;
    logic w_irq_ok;
    logic w_take;
    logic w_restore;
    state_t w_next;

    edge_detect u_nmi_edge (.clock(clock), .reset(reset), .in(bus.nmi_in), .rise(w_rise));

    assign w_idle    = r_state == IDLE;
    assign w_irq_ok  = bus.irq_in & r_ie & ~bus.cpu_busy;
    assign w_take    = ~reset & bus.instr_boundary & w_idle & (r_nmi_pend | w_irq_ok);
    assign w_restore = ~reset & bus.eret & ~w_idle;
    // The unused code 3 falls back to IDLE so a corrupted state cannot lock out interrupts.
    assign w_next = w_take ? (r_nmi_pend ? NMI_SVC : IRQ_SVC) :
                    (w_restore || r_state == state_t'(2'd3)) ? IDLE : r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ie       <= 1'b0;
            r_ie_saved <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_ina      <= 1'b0;
            r_in_nmi   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_next;
            r_nmi_pend <= w_rise | (r_nmi_pend & ~w_take);
            r_ie       <= w_take ? 1'b0 : w_restore ? r_ie_saved :
                          (w_idle & bus.ie_clr) ? 1'b0 : (w_idle & bus.ie_set) ? 1'b1 : r_ie;
            if (w_take) r_ie_saved <= r_ie;
            r_ina      <= w_next != IDLE;
            r_in_nmi   <= w_next == NMI_SVC;
            if (w_take && !(&r_count)) r_count <= r_count + 1'b1;
        end
    end

    assign bus.take        = w_take;
    assign bus.save_pc     = w_take;
    assign bus.vector      = w_take ? (r_nmi_pend ? NMI_VECTOR : IRQ_VECTOR) : '0;
    assign bus.pc_restore  = w_restore;
    assign bus.ina         = r_ina;
    assign bus.in_nmi      = r_in_nmi;
    assign bus.ie          = r_ie;
    assign bus.state       = r_state;
    assign bus.taken_count = r_count;
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: scenario tasks push expected values to a scoreboard and compare them against the DUT.
module tb_interrupt_controller;
    typedef struct {
        string name;
        logic [31:0] val;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic saw_restore = 1'b0;
    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    interrupt_controller_if #(.ADDR_W(32)) bus ();
    interrupt_controller #(.ADDR_W(32), .NMI_VECTOR(32'd20), .IRQ_VECTOR(32'd0)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;
    always @(negedge clock) if (bus.pc_restore === 1'b1) saw_restore <= 1'b1;

    function automatic logic [31:0] obs_of(string n);
        case (n)
            "take":        return 32'(bus.take);
            "save_pc":     return 32'(bus.save_pc);
            "vector":      return bus.vector;
            "pc_restore":  return 32'(bus.pc_restore);
            "ina":         return 32'(bus.ina);
            "in_nmi":      return 32'(bus.in_nmi);
            "ie":          return 32'(bus.ie);
            "state":       return 32'(bus.state);
            "taken_count": return 32'(bus.taken_count);
            "saw_restore": return 32'(saw_restore);
            default:       return 'x;
        endcase
    endfunction

    task automatic push(string n, int v);
        sb.push_back('{n, 32'(v)});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        bus.instr_boundary = 1'b1;
        tick();
        tick();
        #1;
        push("take", 0); push("state", 0); push("ie", 0); push("taken_count", 0); push("ina", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL reset.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            push("take", 0);
            while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL idle_boundary.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        end
        tick();
        bus.instr_boundary = 1'b0;
        push("state", 0); push("ie", 0); push("taken_count", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL idle_end.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
    endtask

    task automatic test_irq();
        exp_t e;
        bus.ie_set = 1'b1;
        tick();
        bus.ie_set = 1'b0;
        bus.irq_in = 1'b1;
        bus.instr_boundary = 1'b1;
        #1;
        push("take", 1); push("vector", 0); push("save_pc", 1);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL irq_take.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        bus.irq_in = 1'b0;
        bus.instr_boundary = 1'b0;
        push("ina", 1); push("state", 1); push("ie", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL irq_svc.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        bus.eret = 1'b1;
        #1;
        push("pc_restore", 1); push("take", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL irq_eret.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        bus.eret = 1'b0;
        push("state", 0); push("ie", 1); push("ina", 0); push("taken_count", 1);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL irq_return.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
    endtask

    task automatic test_busy();
        exp_t e;
        bus.irq_in = 1'b1;
        bus.cpu_busy = 1'b1;
        bus.instr_boundary = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            push("take", 0);
            while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL busy_hold.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
            tick();
        end
        bus.cpu_busy = 1'b0;
        #1;
        push("take", 1); push("vector", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL busy_release.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        bus.instr_boundary = 1'b0;
        bus.irq_in = 1'b0;
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        push("state", 0); push("ie", 1); push("taken_count", 2);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL busy_return.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
    endtask

    task automatic test_nmi_latency();
        exp_t e;
        bus.nmi_in = 1'b1;
        bus.instr_boundary = 1'b1;
        #1;
        push("take", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL nmi_early.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        #1;
        push("take", 1); push("vector", 20); push("save_pc", 1);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL nmi_take.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        bus.instr_boundary = 1'b0;
        push("in_nmi", 1); push("state", 2); push("ina", 1);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL nmi_svc.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        bus.eret = 1'b1;
        #1;
        push("pc_restore", 1);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL nmi_eret.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        bus.eret = 1'b0;
        bus.nmi_in = 1'b0;
        push("state", 0); push("in_nmi", 0); push("taken_count", 3);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL nmi_return.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.ie_set = 1'b1;
        tick();
        bus.ie_set = 1'b0;
        bus.irq_in = 1'b1;
        bus.instr_boundary = 1'b1;
        tick();
        bus.irq_in = 1'b0;
        bus.instr_boundary = 1'b0;
        bus.ie_set = 1'b1;
        tick();
        bus.ie_set = 1'b0;
        push("ie", 0); push("state", 1);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL svc_ie_set.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        for (int i = 0; i < 2; i++) begin
            bus.nmi_in = 1'b1;
            tick();
            bus.nmi_in = 1'b0;
            tick();
        end
        bus.eret = 1'b1;
        bus.instr_boundary = 1'b1;
        #1;
        push("pc_restore", 1); push("take", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL eret_boundary.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        bus.eret = 1'b0;
        #1;
        push("take", 1); push("vector", 20);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL pending_nmi.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        bus.instr_boundary = 1'b0;
        push("taken_count", 2); push("state", 2); push("in_nmi", 1);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL pending_svc.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        bus.instr_boundary = 1'b1;
        #1;
        push("take", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL single_pending.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        bus.instr_boundary = 1'b0;
    endtask

    task automatic test_ie_ctrl();
        exp_t e;
        bus.ie_set = 1'b1;
        bus.ie_clr = 1'b1;
        tick();
        bus.ie_set = 1'b0;
        bus.ie_clr = 1'b0;
        push("ie", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL ie_clr_wins.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        bus.ie_set = 1'b1;
        tick();
        bus.ie_set = 1'b0;
        push("ie", 1);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL ie_set.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
    endtask

    task automatic test_saturate();
        exp_t e;
        int model;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model = 0;
        bus.ie_set = 1'b1;
        tick();
        bus.ie_set = 1'b0;
        for (int i = 0; i < 260; i++) begin
            bus.irq_in = 1'b1;
            bus.instr_boundary = 1'b1;
            tick();
            bus.irq_in = 1'b0;
            bus.instr_boundary = 1'b0;
            bus.eret = 1'b1;
            tick();
            bus.eret = 1'b0;
            model = (model < 255) ? model + 1 : 255;
            if (i == 253 || i == 254 || i == 259) begin
                push("taken_count", model);
                while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL saturate.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
            end
        end
    endtask

    task automatic test_reset_mid_nmi();
        exp_t e;
        bus.nmi_in = 1'b1;
        tick();
        bus.instr_boundary = 1'b1;
        #1;
        push("take", 1); push("vector", 20);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL mid_take.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        bus.instr_boundary = 1'b0;
        bus.nmi_in = 1'b0;
        push("state", 2);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL mid_svc.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        saw_restore = 1'b0;
        reset = 1'b1;
        bus.eret = 1'b1;
        #1;
        push("pc_restore", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL reset_forces.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
        tick();
        tick();
        reset = 1'b0;
        bus.eret = 1'b0;
        #1;
        push("state", 0); push("ina", 0); push("in_nmi", 0); push("taken_count", 0); push("saw_restore", 0);
        while (sb.size() > 0) begin e = sb.pop_front(); checks++; if (obs_of(e.name) !== e.val) begin failures++; $display("FAIL reset_mid.%s got=%0d exp=%0d", e.name, obs_of(e.name), e.val); end end
    endtask

    initial begin
        bus.nmi_in = 1'b0;
        bus.irq_in = 1'b0;
        bus.cpu_busy = 1'b0;
        bus.ie_set = 1'b0;
        bus.ie_clr = 1'b0;
        bus.instr_boundary = 1'b0;
        bus.eret = 1'b0;
        test_reset();
        test_irq();
        test_busy();
        test_nmi_latency();
        test_back_to_back();
        test_ie_ctrl();
        test_saturate();
        test_reset_mid_nmi();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
